// File: rtl/riscv_multi_cycle.sv
// Multi-cycle RV32I-subset core with a unified word-addressed memory.
// Instructions step through FETCH/DECODE/EXECUTE, then MEMORY and/or WRITEBACK as needed.

module riscv_mem #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] i_ridx,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_widx,
  input  logic [31:0]   i_wdata
);
  logic [31:0] mem [0:MEM_WORDS-1];

  assign o_rdata = mem[i_ridx];

  // Whole-word synchronous write; contents are never cleared by reset.
  always @(posedge clk) begin
    if (i_we) begin
      mem[i_widx] <= i_wdata;
    end
  end
endmodule

module riscv_multi_cycle #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXECUTE   = 4'd2,
    MEMORY    = 4'd3,
    WRITEBACK = 4'd4
  } state_t;

  state_t      state, w_next_state;
  logic [31:0] PC, IR;
  logic [31:0] RegisterFile [0:31];
  logic [31:0] r_old_pc, r_a, r_b, r_imm, r_alu_out, r_mdr;

  logic [6:0]    w_opcode;
  logic [4:0]    w_rd, w_rs1, w_rs2;
  logic [2:0]    w_funct3;
  logic          w_funct7_5, w_alt, w_taken, w_is_wb, w_mem_we;
  logic [31:0]   w_op_b, w_alu, w_wb_data, w_mem_rdata;
  logic [AW-1:0] w_mem_idx;

  function automatic logic [31:0] imm_gen(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      OP_I, OP_LW, OP_JALR: imm = {{20{ir[31]}}, ir[31:20]};
      OP_SW:                imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BR:                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:     imm = {ir[31:12], 12'h000};
      OP_JAL:               imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:              imm = 32'd0;
    endcase
    return imm;
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    logic [31:0]        res;
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'b000: res = alt ? (a - b) : (a + b);
      3'b001: res = a << b[4:0];
      3'b010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: res = (a < b) ? 32'd1 : 32'd0;
      3'b100: res = a ^ b;
      3'b101: begin
        if (alt) res = sa >>> b[4:0];
        else     res = a >> b[4:0];
      end
      3'b110: res = a | b;
      3'b111: res = a & b;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  assign w_opcode   = IR[6:0];
  assign w_rd       = IR[11:7];
  assign w_funct3   = IR[14:12];
  assign w_rs1      = IR[19:15];
  assign w_rs2      = IR[24:20];
  assign w_funct7_5 = IR[30];

  // For I-type only the shift-right encoding uses funct7[5] (SRAI vs SRLI).
  always_comb begin
    w_op_b  = (w_opcode == OP_R) ? r_b : r_imm;
    w_alt   = w_funct7_5 & ((w_opcode == OP_R) | (w_funct3 == 3'b101));
    w_taken = (w_opcode == OP_BR) &
              (((w_funct3 == 3'b000) & (r_a == r_b)) | ((w_funct3 == 3'b001) & (r_a != r_b)));
    w_is_wb = (w_opcode == OP_R) | (w_opcode == OP_I) | (w_opcode == OP_LUI) |
              (w_opcode == OP_AUIPC) | (w_opcode == OP_JAL) | (w_opcode == OP_JALR);
    case (w_opcode)
      OP_R, OP_I:   w_alu = alu(r_a, w_op_b, w_funct3, w_alt);
      OP_LW, OP_SW: w_alu = r_a + r_imm;
      OP_LUI:       w_alu = r_imm;
      OP_AUIPC:     w_alu = r_old_pc + r_imm;
      default:      w_alu = r_old_pc + 32'd4;
    endcase
    case (w_opcode)
      OP_LW:           w_wb_data = r_mdr;
      OP_JAL, OP_JALR: w_wb_data = r_old_pc + 32'd4;
      default:         w_wb_data = r_alu_out;
    endcase
  end

  always_comb begin
    w_next_state = FETCH;
    w_mem_we     = 1'b0;
    w_mem_idx    = r_alu_out[AW+1:2];
    case (state)
      FETCH: begin
        w_next_state = DECODE;
        w_mem_idx    = PC[AW+1:2];
      end
      DECODE: w_next_state = EXECUTE;
      EXECUTE: begin
        if ((w_opcode == OP_LW) || (w_opcode == OP_SW)) w_next_state = MEMORY;
        else if (w_is_wb)                               w_next_state = WRITEBACK;
        else                                            w_next_state = FETCH;
      end
      MEMORY: begin
        if (w_opcode == OP_LW) begin
          w_next_state = WRITEBACK;
        end else begin
          w_next_state = FETCH;
          w_mem_we     = reset;
        end
      end
      WRITEBACK: w_next_state = FETCH;
      default:   w_next_state = FETCH;
    endcase
  end

  riscv_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) memory (
    .clk     (clk),
    .i_ridx  (w_mem_idx),
    .o_rdata (w_mem_rdata),
    .i_we    (w_mem_we),
    .i_widx  (r_alu_out[AW+1:2]),
    .i_wdata (r_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= w_next_state;
  end

  // Datapath registers; PC is redirected in EXECUTE for taken branches and jumps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC        <= RESET_PC;
      IR        <= 32'd0;
      r_old_pc  <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_imm     <= 32'd0;
      r_alu_out <= 32'd0;
      r_mdr     <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          IR       <= w_mem_rdata;
          r_old_pc <= PC;
          PC       <= PC + 32'd4;
        end
        DECODE: begin
          r_a   <= RegisterFile[w_rs1];
          r_b   <= RegisterFile[w_rs2];
          r_imm <= imm_gen(IR);
        end
        EXECUTE: begin
          r_alu_out <= w_alu;
          if (w_taken || (w_opcode == OP_JAL)) PC <= r_old_pc + r_imm;
          else if (w_opcode == OP_JALR)        PC <= (r_a + r_imm) & ~32'd1;
        end
        MEMORY: begin
          if (w_opcode == OP_LW) r_mdr <= w_mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) RegisterFile[i] <= 32'd0;
    end else if ((state == WRITEBACK) && (w_rd != 5'd0)) begin
      RegisterFile[w_rd] <= w_wb_data;
    end
  end
endmodule

// File: tb/tb_riscv_multi_cycle.sv
// Directed bench for riscv_multi_cycle: preloads programs into memory and checks
// architectural state after hand-counted numbers of clock edges.

module tb_riscv_multi_cycle;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  riscv_multi_cycle #(.MEM_WORDS(256), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) dut.memory.mem[i] = 32'h0000_0000;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OPLW = 7'b0000011;

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;

    // ---- Program 1: ADDI/ADD, then SW/LW round trip ----
    clear_mem();
    dut.memory.mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
    dut.memory.mem[1] = enc_i(12'd7, 5'd0, 3'b000, 5'd2, OPI);
    dut.memory.mem[2] = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
    dut.memory.mem[3] = enc_s(12'd64, 5'd3, 5'd0);
    dut.memory.mem[4] = enc_i(12'd64, 5'd0, 3'b010, 5'd4, OPLW);
    step(2);
    check("reset_pc", dut.PC, 32'h0);
    check("reset_ir", dut.IR, 32'h0);
    check("reset_state", 32'(dut.state), 32'd0);
    check("reset_x31", dut.RegisterFile[31], 32'h0);

    release_reset();
    step(12);
    check("addi_x1", dut.RegisterFile[1], 32'd5);
    check("addi_x2", dut.RegisterFile[2], 32'd7);
    check("add_x3", dut.RegisterFile[3], 32'h0000_000C);
    check("pc_after_3", dut.PC, 32'h0000_000C);
    check("state_fetch_12", 32'(dut.state), 32'd0);
    step(4);
    check("sw_mem16", dut.memory.mem[16], 32'h0000_000C);
    check("pc_after_sw", dut.PC, 32'h0000_0010);
    step(3);
    check("lw_in_memory", 32'(dut.state), 32'd3);
    step(1);
    check("lw_in_writeback", 32'(dut.state), 32'd4);
    check("lw_x4_pending", dut.RegisterFile[4], 32'h0);
    step(1);
    check("lw_x4", dut.RegisterFile[4], 32'h0000_000C);
    check("lw_pc", dut.PC, 32'h0000_0014);
    check("lw_done_fetch", 32'(dut.state), 32'd0);

    // ---- Program 2: BEQ taken ----
    reset = 1'b0;
    clear_mem();
    dut.memory.mem[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd1, OPI);
    dut.memory.mem[1] = enc_i(12'd3, 5'd0, 3'b000, 5'd2, OPI);
    dut.memory.mem[4] = enc_b(13'd8, 5'd2, 5'd1, 3'b000);
    dut.memory.mem[5] = enc_i(12'd1, 5'd0, 3'b000, 5'd6, OPI);
    step(2);
    release_reset();
    step(17);
    check("beq_pc", dut.PC, 32'h0000_0018);
    check("beq_state", 32'(dut.state), 32'd0);
    step(3);
    check("beq_skip_x6", dut.RegisterFile[6], 32'h0);
    check("beq_nop_pc", dut.PC, 32'h0000_001C);

    // ---- Program 3: BNE not taken ----
    reset = 1'b0;
    dut.memory.mem[4] = enc_b(13'd8, 5'd2, 5'd1, 3'b001);
    step(2);
    release_reset();
    step(17);
    check("bne_pc", dut.PC, 32'h0000_0014);
    step(4);
    check("bne_fall_x6", dut.RegisterFile[6], 32'd1);

    // ---- Program 4: x0, signed compares, shifts, SUB, JAL, LUI, JALR ----
    reset = 1'b0;
    clear_mem();
    dut.memory.mem[0]  = enc_i(12'd3, 5'd0, 3'b000, 5'd5, OPI);
    dut.memory.mem[1]  = enc_i(12'd9, 5'd0, 3'b000, 5'd0, OPI);
    dut.memory.mem[2]  = enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd5);
    dut.memory.mem[3]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OPI);
    dut.memory.mem[4]  = enc_r(7'd0, 5'd0, 5'd1, 3'b010, 5'd2);
    dut.memory.mem[5]  = enc_r(7'd0, 5'd0, 5'd1, 3'b011, 5'd3);
    dut.memory.mem[6]  = enc_i(12'h404, 5'd1, 3'b101, 5'd4, OPI);
    dut.memory.mem[7]  = enc_i(12'd28, 5'd1, 3'b101, 5'd6, OPI);
    dut.memory.mem[8]  = enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd7);
    dut.memory.mem[9]  = enc_j(21'd8, 5'd8);
    dut.memory.mem[10] = enc_i(12'd1, 5'd0, 3'b000, 5'd9, OPI);
    dut.memory.mem[11] = {20'h12345, 5'd10, 7'b0110111};
    dut.memory.mem[12] = enc_i(12'd0, 5'd8, 3'b000, 5'd11, 7'b1100111);
    step(2);
    release_reset();
    step(12);
    check("x0_reads_zero", dut.RegisterFile[0], 32'h0);
    check("add_x5_zero", dut.RegisterFile[5], 32'h0);
    step(24);
    check("addi_neg_x1", dut.RegisterFile[1], 32'hFFFF_FFFF);
    check("slt_x2", dut.RegisterFile[2], 32'd1);
    check("sltu_x3", dut.RegisterFile[3], 32'd0);
    check("srai_x4", dut.RegisterFile[4], 32'hFFFF_FFFF);
    check("srli_x6", dut.RegisterFile[6], 32'h0000_000F);
    check("sub_x7", dut.RegisterFile[7], 32'd2);
    step(4);
    check("jal_pc", dut.PC, 32'h0000_002C);
    check("jal_link_x8", dut.RegisterFile[8], 32'h0000_0028);
    step(4);
    check("lui_x10", dut.RegisterFile[10], 32'h1234_5000);
    check("jal_skipped_x9", dut.RegisterFile[9], 32'h0);
    step(4);
    check("jalr_pc", dut.PC, 32'h0000_0028);
    check("jalr_link_x11", dut.RegisterFile[11], 32'h0000_0034);

    // ---- Program 5: asynchronous reset aborts an in-flight SW ----
    reset = 1'b0;
    clear_mem();
    dut.memory.mem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
    dut.memory.mem[1]  = enc_s(12'h080, 5'd1, 5'd0);
    dut.memory.mem[32] = 32'hDEAD_BEEF;
    step(2);
    release_reset();
    step(4);
    check("abort_pre_x1", dut.RegisterFile[1], 32'd5);
    step(2);
    check("abort_in_execute", 32'(dut.state), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("async_state", 32'(dut.state), 32'd0);
    check("async_pc", dut.PC, 32'h0);
    check("async_x1", dut.RegisterFile[1], 32'h0);
    step(3);
    check("abort_mem32", dut.memory.mem[32], 32'hDEAD_BEEF);
    check("abort_mem1", dut.memory.mem[1], enc_s(12'h080, 5'd1, 5'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_multi_cycle.md
RISCV_MULTI_CYCLE -- requirements
Module: riscv_multi_cycle

Interface
REQ-001 Parameter MEM_WORDS, default 256: unified instruction/data memory depth in 32-bit words.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low; takes effect immediately when low, independent of clk.
REQ-005 No other ports; the block is self-contained, with program and data held in internal memory.
REQ-006 Hierarchical names SHALL be provided for bench access: PC[31:0], IR[31:0], state[3:0], RegisterFile[0:31] (32x32), and submemory instance "memory" with word array mem[0:MEM_WORDS-1].
REQ-007 State encodings SHALL be named constants: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4; values 5-15 are unused.

Function
REQ-008 The memory SHALL be word-addressed; byte address A maps to mem[A[log2(MEM_WORDS)+1:2]]; address bits [1:0] are ignored; out-of-range upper bits wrap.
REQ-009 Memory reads SHALL be combinational; writes SHALL be synchronous, whole-word.
REQ-010 FETCH: IR<=mem[PC]; OldPC<=PC; PC<=PC+4; next state DECODE.
REQ-011 DECODE: A<=RegisterFile[rs1], B<=RegisterFile[rs2], Imm<=sign-extended immediate per the I/S/B/U/J format; next state EXECUTE.
REQ-012 EXECUTE: ALUOut<=result; next state MEMORY for LW/SW, FETCH for BEQ/BNE/unknown opcodes, and WRITEBACK otherwise.
REQ-013 Supported R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU; shift amounts use B[4:0].
REQ-014 Supported I-type: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI; shift amounts use imm[4:0], and SRAI is selected by funct7[5].
REQ-015 Also supported: LW, SW, BEQ, BNE, JAL, JALR, LUI, AUIPC; any other opcode SHALL execute as a NOP (PC advances by 4, no register or memory write).
REQ-016 Branches SHALL resolve in EXECUTE: if taken, PC<=OldPC+Imm; otherwise PC stays at OldPC+4.
REQ-017 JAL SHALL set PC<=OldPC+Imm in EXECUTE.
REQ-018 JALR SHALL set PC<=(A+Imm)&~1 in EXECUTE.
REQ-019 For both JAL and JALR, rd SHALL receive OldPC+4 in WRITEBACK.
REQ-020 MEMORY: SW writes B to mem[ALUOut] and goes to FETCH; LW sets MDR<=mem[ALUOut] and goes to WRITEBACK.
REQ-021 WRITEBACK: RegisterFile[rd]<= MDR for LW, OldPC+4 for JAL/JALR, or ALUOut otherwise; next state FETCH.
REQ-022 Writes to x0 SHALL be discarded; reads of x0 SHALL return 0.
REQ-023 Cycles per instruction SHALL be: BEQ/BNE/NOP 3; ALU, LUI, AUIPC, JAL, JALR and SW 4; LW 5.
REQ-024 Arithmetic SHALL be 32-bit modulo 2^32 with no overflow trap; SLT is signed and SLTU is unsigned.
REQ-025 Misaligned addresses SHALL be silently word-truncated; no exceptions, interrupts, CSRs, byte or halfword accesses.

Reset
REQ-026 While reset is low: PC=RESET_PC, IR=0, state=FETCH, all RegisterFile entries=0, A/B/Imm/ALUOut/MDR/OldPC=0.
REQ-027 Assertion mid-instruction SHALL abort that instruction immediately, with no pending register or memory write.
REQ-028 Memory contents SHALL NOT be cleared by reset; the bench preloads mem[] before releasing reset.
REQ-029 The first FETCH SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-030 Preload ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2; release reset -> after 12 edges x1=5, x2=7, x3=0x0000000C, PC=0x0C.
REQ-031 Execute SW x3,64(x0) with x3=0xC, then LW x4,64(x0) -> mem[16]=0x0000000C; x4=0x0000000C; LW spends 5 cycles, including one MEMORY state.
REQ-032 With x1=x2, BEQ x1,x2,+8 at PC 0x10 -> PC=0x18 and the instruction at 0x14 never executes; BNE in the same setup -> PC=0x14.
REQ-033 ADDI x0,x0,9 followed by ADD x5,x0,x0 -> x0 reads 0 and x5=0.
REQ-034 ADDI x1,x0,-1; SLT x2,x1,x0; SLTU x3,x1,x0; SRAI x4,x1,4 -> x2=1, x3=0, x4=0xFFFFFFFF.
REQ-035 Drive reset low asynchronously while state=EXECUTE -> state=FETCH and PC=0 without waiting for a clock edge; registers=0; memory unchanged.
